// File: rtl/cycle_ctrl.sv
// cycle_ctrl: instruction sequencer for a small CPU.
// Phases are IDLE -> FETCH -> EXEC1 [-> EXEC2] -> FETCH or IDLE.
// RUN or STEP leaves IDLE. STOP, STP or step mode return the block to IDLE
// at the next instruction boundary. RETIRED counts completed instructions.
// The RETIRED_RST parameter sets the counter's reset value. It defaults to
// zero. A nonzero value is a bring-up aid for reaching the wrap point quickly.
module cycle_ctrl #(
  parameter logic [15:0] RETIRED_RST = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic        STEP,
  input  logic        STOP,
  input  logic        E2,
  input  logic        STP,
  input  logic [15:0] INSTR_IN,
  output logic        FETCH,
  output logic        EXEC1,
  output logic        EXEC2,
  output logic        HALTED,
  output logic [15:0] IR,
  output logic [15:0] RETIRED
);

  typedef enum logic [1:0] {IDLE, S_FETCH, S_EXEC1, S_EXEC2} state_t;

  state_t      state_q, state_d;
  logic        step_q, step_d;
  logic        stop_pend_q, stop_pend_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic        fetch_q, exec1_q, exec2_q, halted_q;
  logic        retire;
  logic        boundary_idle;

  // State register. The phase strobes are registered decodes of the next
  // state, so they line up exactly with state_q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      step_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      ir_q        <= 16'h0000;
      retired_q   <= RETIRED_RST;
      fetch_q     <= 1'b0;
      exec1_q     <= 1'b0;
      exec2_q     <= 1'b0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      stop_pend_q <= stop_pend_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      fetch_q     <= (state_d == S_FETCH);
      exec1_q     <= (state_d == S_EXEC1);
      exec2_q     <= (state_d == S_EXEC2);
      halted_q    <= (state_d == IDLE);
    end
  end

  // Next-state logic: phase sequencing, IR load, stop latch and retire count.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    ir_d      = ir_q;
    retire    = 1'b0;
    // A STOP that arrives in the boundary cycle itself still counts.
    boundary_idle = stop_pend_q | STOP | step_q;
    unique case (state_q)
      IDLE: begin
        if (RUN) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
        end else if (STEP) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC1;
        ir_d    = INSTR_IN;
      end
      S_EXEC1: begin
        if (STP) begin
          state_d = IDLE;
          retire  = 1'b1;
        end else if (E2) begin
          state_d = S_EXEC2;
        end else begin
          state_d = boundary_idle ? IDLE : S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC2: begin
        state_d = boundary_idle ? IDLE : S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // The stop latch clears on entry to IDLE. STOP received while IDLE is dropped.
    if (state_d == IDLE)
      stop_pend_d = 1'b0;
    else if (state_q != IDLE && STOP)
      stop_pend_d = 1'b1;
    else
      stop_pend_d = stop_pend_q;
    retired_d = retired_q + {15'd0, retire};
  end

  // Output drive.
  always_comb begin
    FETCH   = fetch_q;
    EXEC1   = exec1_q;
    EXEC2   = exec2_q;
    HALTED  = halted_q;
    IR      = ir_q;
    RETIRED = retired_q;
  end

endmodule

// File: tb/tb_cycle_ctrl.sv
// Directed bench for cycle_ctrl. The phase outputs are viewed as the vector
// {HALTED,FETCH,EXEC1,EXEC2}. A second instance, preloaded near 0xFFFF,
// checks the RETIRED counter wrap.
module tb_cycle_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b0, RUN = 1'b0, STEP = 1'b0, STOP = 1'b0;
  logic        E2 = 1'b0, STP = 1'b0;
  logic [15:0] INSTR_IN = 16'h0000;
  logic        FETCH, EXEC1, EXEC2, HALTED;
  logic [15:0] IR, RETIRED;
  logic        RST_w = 1'b0, RUN_w = 1'b0, STEP_w = 1'b0;
  logic        FETCH_w, EXEC1_w, EXEC2_w, HALTED_w;
  logic [15:0] IR_w, RETIRED_w;
  int checks = 0, errors = 0;

  localparam logic [3:0] PH_I = 4'b1000, PH_F = 4'b0100, PH_1 = 4'b0010, PH_2 = 4'b0001;
  wire [3:0] ph   = {HALTED, FETCH, EXEC1, EXEC2};
  wire [3:0] ph_w = {HALTED_w, FETCH_w, EXEC1_w, EXEC2_w};

  always #5 CLK = ~CLK;

  cycle_ctrl dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .STOP(STOP), .E2(E2), .STP(STP),
    .INSTR_IN(INSTR_IN), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2),
    .HALTED(HALTED), .IR(IR), .RETIRED(RETIRED)
  );

  cycle_ctrl #(.RETIRED_RST(16'hFFFD)) u_wrap (
    .CLK(CLK), .RST(RST_w), .RUN(RUN_w), .STEP(STEP_w), .STOP(STOP), .E2(E2), .STP(STP),
    .INSTR_IN(INSTR_IN), .FETCH(FETCH_w), .EXEC1(EXEC1_w), .EXEC2(EXEC2_w),
    .HALTED(HALTED_w), .IR(IR_w), .RETIRED(RETIRED_w)
  );

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; RST_w = 1'b1; #3;
    checks++; if (ph !== PH_I) begin errors++; $display("FAIL reset_phase got %b exp %b", ph, PH_I); end
    checks++; if (IR !== 16'h0000 || RETIRED !== 16'h0000) begin errors++; $display("FAIL reset_regs got IR=%h RET=%h exp 0000/0000", IR, RETIRED); end
    @(negedge CLK); RST = 1'b0; RST_w = 1'b0;
    tick(); tick();
    checks++; if (ph !== PH_I) begin errors++; $display("FAIL reset_stays_idle got %b exp %b", ph, PH_I); end
  endtask

  task automatic test_run();
    INSTR_IN = 16'h1234; RUN = 1'b1;
    tick(); RUN = 1'b0;
    checks++; if (ph !== PH_F) begin errors++; $display("FAIL run_fetch got %b exp %b", ph, PH_F); end
    tick();
    checks++; if (ph !== PH_1 || IR !== 16'h1234) begin errors++; $display("FAIL run_exec1 got %b IR=%h exp %b IR=1234", ph, IR, PH_1); end
    tick();
    checks++; if (ph !== PH_F || RETIRED !== 16'd1) begin errors++; $display("FAIL run_fetch2 got %b RET=%0d exp %b RET=1", ph, RETIRED, PH_F); end
    tick(); tick();
    checks++; if (ph !== PH_F || RETIRED !== 16'd2) begin errors++; $display("FAIL run_fetch3 got %b RET=%0d exp %b RET=2", ph, RETIRED, PH_F); end
  endtask

  task automatic test_e2();
    E2 = 1'b1; tick();
    tick(); E2 = 1'b0;
    checks++; if (ph !== PH_2 || RETIRED !== 16'd2) begin errors++; $display("FAIL e2_exec2 got %b RET=%0d exp %b RET=2", ph, RETIRED, PH_2); end
    tick();
    checks++; if (ph !== PH_F || RETIRED !== 16'd3) begin errors++; $display("FAIL e2_retire got %b RET=%0d exp %b RET=3", ph, RETIRED, PH_F); end
  endtask

  task automatic test_stop();
    STOP = 1'b1; tick(); STOP = 1'b0;
    checks++; if (ph !== PH_1) begin errors++; $display("FAIL stop_completes got %b exp %b", ph, PH_1); end
    tick();
    checks++; if (ph !== PH_I || RETIRED !== 16'd4) begin errors++; $display("FAIL stop_idle got %b RET=%0d exp %b RET=4", ph, RETIRED, PH_I); end
    tick();
    checks++; if (ph !== PH_I) begin errors++; $display("FAIL stop_sticky got %b exp %b", ph, PH_I); end
  endtask

  task automatic test_stp();
    RUN = 1'b1; tick(); RUN = 1'b0;
    tick(); STP = 1'b1; E2 = 1'b1;
    tick(); STP = 1'b0; E2 = 1'b0;
    checks++; if (ph !== PH_I || RETIRED !== 16'd5) begin errors++; $display("FAIL stp_halt got %b RET=%0d exp %b RET=5", ph, RETIRED, PH_I); end
    tick();
    checks++; if (ph !== PH_I) begin errors++; $display("FAIL stp_sticky got %b exp %b", ph, PH_I); end
  endtask

  task automatic test_step();
    RST = 1'b1; #2; RST = 1'b0;
    tick(); STEP = 1'b1; INSTR_IN = 16'hBEEF;
    tick(); STEP = 1'b0;
    tick();
    checks++; if (ph !== PH_1 || IR !== 16'hBEEF) begin errors++; $display("FAIL step_exec1 got %b IR=%h exp %b IR=beef", ph, IR, PH_1); end
    tick();
    checks++; if (ph !== PH_I || RETIRED !== 16'd1) begin errors++; $display("FAIL step1_idle got %b RET=%0d exp %b RET=1", ph, RETIRED, PH_I); end
    STEP = 1'b1; tick(); STEP = 1'b0;
    tick(); E2 = 1'b1;
    tick(); E2 = 1'b0;
    checks++; if (ph !== PH_2) begin errors++; $display("FAIL step2_exec2 got %b exp %b", ph, PH_2); end
    tick();
    checks++; if (ph !== PH_I || RETIRED !== 16'd2) begin errors++; $display("FAIL step2_idle got %b RET=%0d exp %b RET=2", ph, RETIRED, PH_I); end
  endtask

  task automatic test_level_restart();
    RUN = 1'b1; tick();
    tick(); STP = 1'b1;
    tick(); STP = 1'b0;
    checks++; if (ph !== PH_I || RETIRED !== 16'd3) begin errors++; $display("FAIL lvl_halt got %b RET=%0d exp %b RET=3", ph, RETIRED, PH_I); end
    tick(); RUN = 1'b0;
    checks++; if (ph !== PH_F) begin errors++; $display("FAIL lvl_restart got %b exp %b", ph, PH_F); end
    tick(); STOP = 1'b1;
    tick(); STOP = 1'b0;
    checks++; if (ph !== PH_I || RETIRED !== 16'd4) begin errors++; $display("FAIL stop_boundary got %b RET=%0d exp %b RET=4", ph, RETIRED, PH_I); end
  endtask

  task automatic test_run_wins();
    STOP = 1'b1; tick(); STOP = 1'b0;
    RUN = 1'b1; STEP = 1'b1; tick(); RUN = 1'b0; STEP = 1'b0;
    tick(); tick();
    checks++; if (ph !== PH_F || RETIRED !== 16'd5) begin errors++; $display("FAIL run_wins got %b RET=%0d exp %b RET=5", ph, RETIRED, PH_F); end
  endtask

  task automatic test_async_reset();
    tick(); E2 = 1'b1;
    tick(); E2 = 1'b0;
    checks++; if (ph !== PH_2) begin errors++; $display("FAIL pre_reset got %b exp %b", ph, PH_2); end
    #2 RST = 1'b1; #1;
    checks++; if (ph !== PH_I || IR !== 16'h0000 || RETIRED !== 16'h0000) begin errors++; $display("FAIL async_reset got %b IR=%h RET=%h exp %b 0000 0000", ph, IR, RETIRED, PH_I); end
    #1 RST = 1'b0;
    tick(); tick();
    checks++; if (ph !== PH_I || RETIRED !== 16'h0000) begin errors++; $display("FAIL post_reset got %b RET=%h exp %b 0000", ph, RETIRED, PH_I); end
  endtask

  task automatic test_wrap();
    RUN_w = 1'b1; tick(); RUN_w = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (ph_w !== PH_F || RETIRED_w !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %b RET=%h exp %b ffff", ph_w, RETIRED_w, PH_F); end
    tick(); tick();
    checks++; if (RETIRED_w !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", RETIRED_w); end
  endtask

  initial begin
    #1;
    test_reset();
    test_run();
    test_e2();
    test_stop();
    test_stp();
    test_step();
    test_level_restart();
    test_run_wins();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
